// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port (optional FIFO_ARB_STATS_EN)
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DAT_WIDTH = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*DAT_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]           gnt,
   output logic                       fifo_wr,
   output logic [DAT_WIDTH-1:0]       fifo_din,
   input  logic                       fifo_full
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [15:0]                stall_cnt
`endif
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic            grant_en;
   logic [IW-1:0]   grant_idx;
   logic [BW-1:0]   bcnt_inc;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      if (int'(idx) == N_REQ - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // Round-robin search for the first requester starting at rr_ptr
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int j;
         j = (int'(rr_ptr_q) + k) % N_REQ;
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = IW'(j);
         end
      end
   end

   // Zero-latency accept: pick the granted port this cycle, never while full or in reset
   always_comb begin
      grant_en  = 1'b0;
      grant_idx = '0;
      if (state_q == IDLE) begin
         grant_en  = win_found && !fifo_full;
         grant_idx = win_idx;
      end else begin
         grant_en  = req[owner_q] && !fifo_full;
         grant_idx = owner_q;
      end
      if (reset) begin
         grant_en = 1'b0;
      end
   end

   // Drive the one-hot accept and the FIFO write pins from the selected port
   always_comb begin
      gnt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         gnt[i] = grant_en && (int'(grant_idx) == i);
      end
      fifo_wr  = grant_en;
      fifo_din = grant_en ? req_data[int'(grant_idx)*DAT_WIDTH +: DAT_WIDTH] : '0;
   end

   assign bcnt_inc = bcnt_q + 1'b1;

   // Next-state for the burst FSM, owner, round-robin pointer and burst counter
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      bcnt_d   = bcnt_q;
      case (state_q)
         IDLE: begin
            if (grant_en) begin
               owner_d = win_idx;
               bcnt_d  = BW'(1);
               if (MAX_BURST == 1) begin
                  rr_ptr_d = next_idx(win_idx);
               end else begin
                  state_d = BURST;
               end
            end
         end
         BURST: begin
            if (!req[owner_q]) begin
               // Owner withdrew: give up the port, costing one bubble cycle
               rr_ptr_d = next_idx(owner_q);
               state_d  = IDLE;
            end else if (grant_en) begin
               bcnt_d = bcnt_inc;
               if (bcnt_inc == BW'(MAX_BURST)) begin
                  rr_ptr_d = next_idx(owner_q);
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbitration state registers with asynchronous reset back to port 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         bcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         bcnt_q   <= bcnt_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of cycles where someone wanted to write but the FIFO was full
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if ((|req) && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        fifo_wr;
   logic [7:0]  fifo_din;
   logic        fifo_full;
`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   fifo_wr_arbiter #(.N_REQ(4), .DAT_WIDTH(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .fifo_full (fifo_full)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check outputs mid-cycle, then advance to just after the next rising edge
   task automatic cyc(input string tag, input logic [3:0] eg, input logic [7:0] ed);
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_wr"}, 32'(fifo_wr), 32'(|eg));
      chk({tag, "_din"}, 32'(fifo_din), 32'(ed));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req       = 4'b0000;
      fifo_full = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      reset     = 1'b1;
      req       = 4'b1111;
      fifo_full = 1'b0;
      #3;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_wr", 32'(fifo_wr), 32'h0);
      chk("rst_din", 32'(fifo_din), 32'h0);
`ifdef FIFO_ARB_STATS_EN
      chk("rst_stall", 32'(stall_cnt), 32'h0);
`endif

      // Single requester p2: burst of 4, then re-granted via IDLE after rr_ptr wraps
      do_reset();
      req = 4'b0100;
      for (int i = 1; i <= 4; i++) cyc($sformatf("t1_w%0d", i), 4'b0100, 8'hA5);
      cyc("t1_w5", 4'b0100, 8'hA5);
      cyc("t1_w6", 4'b0100, 8'hA5);

      // All requesting: p0,p1,p2,p3 bursts of 4 back to back, then wrap to p0
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 4; i++) cyc($sformatf("t2_p0_%0d", i), 4'b0001, 8'h11);
      for (int i = 0; i < 4; i++) cyc($sformatf("t2_p1_%0d", i), 4'b0010, 8'h22);
      for (int i = 0; i < 4; i++) cyc($sformatf("t2_p2_%0d", i), 4'b0100, 8'hA5);
      for (int i = 0; i < 4; i++) cyc($sformatf("t2_p3_%0d", i), 4'b1000, 8'h44);
      cyc("t2_wrap", 4'b0001, 8'h11);

      // FIFO full mid-burst: stall, then the same owner finishes, then rotate
      do_reset();
      req = 4'b0011;
      cyc("t3_w1", 4'b0001, 8'h11);
      cyc("t3_w2", 4'b0001, 8'h11);
      fifo_full = 1'b1;
      cyc("t3_full1", 4'b0000, 8'h00);
      cyc("t3_full2", 4'b0000, 8'h00);
      fifo_full = 1'b0;
      cyc("t3_w3", 4'b0001, 8'h11);
      cyc("t3_w4", 4'b0001, 8'h11);
      cyc("t3_rot", 4'b0010, 8'h22);

      // Owner drops after 2 writes: one bubble, then waiting p3 wins
      do_reset();
      req = 4'b1001;
      cyc("t4_w1", 4'b0001, 8'h11);
      cyc("t4_w2", 4'b0001, 8'h11);
      req = 4'b1000;
      cyc("t4_bubble", 4'b0000, 8'h00);
      cyc("t4_p3", 4'b1000, 8'h44);

      // Full while idle: nothing granted until it clears
      do_reset();
      fifo_full = 1'b1;
      req = 4'b0010;
      cyc("t4b_full", 4'b0000, 8'h00);
      fifo_full = 1'b0;
      cyc("t4b_go", 4'b0010, 8'h22);

      // Async reset pulse mid-burst
      do_reset();
      req = 4'b0100;
      cyc("t5_w1", 4'b0100, 8'hA5);
      cyc("t5_w2", 4'b0100, 8'hA5);
      req = 4'b1111;
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_gnt", 32'(gnt), 32'h0);
      chk("t5_async_wr", 32'(fifo_wr), 32'h0);
      chk("t5_async_din", 32'(fifo_din), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("t5_after1", 4'b0001, 8'h11);
      cyc("t5_after2", 4'b0001, 8'h11);

`ifdef FIFO_ARB_STATS_EN
      // Stall counter counts full cycles with a pending request and saturates
      do_reset();
      fifo_full = 1'b1;
      req = 4'b0001;
      repeat (10) @(posedge clk);
      #1;
      chk("t6_stall10", 32'(stall_cnt), 32'd10);
      repeat (70000) @(posedge clk);
      #1;
      chk("t6_sat", 32'(stall_cnt), 32'hFFFF);
      chk("t6_gnt", 32'(gnt), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
